// File: rtl/stage_pipe_reg.sv
// Two-entry pipeline stage register: a main register drives the outputs and a skid
// register absorbs one extra entry, so in_ready depends only on registered state.
module stage_pipe_reg #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0000,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_npc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_npc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              in_fire, out_fire;
  logic              ld_main_in, ld_main_skid, ld_skid;
  logic [INST_W-1:0] m_inst, s_inst;
  logic [ADDR_W-1:0] m_pc, m_npc, s_pc, s_npc;

  assign in_ready  = (state != FULL);
  assign out_valid = (state == ONE) || (state == FULL);
  assign occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // An empty stage presents a bubble regardless of stale main-register contents.
  assign out_inst = out_valid ? m_inst : NOP_INST;
  assign out_pc   = out_valid ? m_pc   : '0;
  assign out_npc  = out_valid ? m_npc  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          ld_main_in = 1'b1;
          state_nxt  = ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nxt    = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inst <= NOP_INST;
      m_pc   <= '0;
      m_npc  <= '0;
      s_inst <= NOP_INST;
      s_pc   <= '0;
      s_npc  <= '0;
    end else begin
      if (ld_main_in) begin
        m_inst <= in_inst;
        m_pc   <= in_pc;
        m_npc  <= in_npc;
      end else if (ld_main_skid) begin
        m_inst <= s_inst;
        m_pc   <= s_pc;
        m_npc  <= s_npc;
      end
      if (ld_skid) begin
        s_inst <= in_inst;
        s_pc   <= in_pc;
        s_npc  <= in_npc;
      end
    end
  end

  // Back-pressure counter; a flushing cycle is not a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Directed bench for stage_pipe_reg: a queue model of the stage checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_stage_pipe_reg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready;
  logic [INST_W-1:0] in_inst = '0;
  logic [ADDR_W-1:0] in_pc = '0, in_npc = '0;
  logic              flush = 1'b0;
  logic              out_valid, out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc, out_npc;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  stage_pipe_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc), .in_npc(in_npc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_npc(out_npc), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two entries.
  typedef struct { logic [31:0] inst, pc, npc; } ent_t;
  ent_t q[$];
  int   m_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_stall = 0;
    end else begin
      automatic bit vld = (q.size() > 0);
      automatic bit rdy = (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (vld && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
        if (vld && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back('{in_inst, in_pc, in_npc});
      end
    end
  end

  always @(negedge clk) begin
    automatic int sz = q.size();
    check("m_occupancy", 64'(occupancy), 64'(sz));
    check("m_out_valid", 64'(out_valid), 64'(sz > 0));
    check("m_in_ready",  64'(in_ready),  64'(sz < 2));
    check("m_out_inst",  64'(out_inst),  sz > 0 ? 64'(q[0].inst) : 64'(NOP));
    check("m_out_pc",    64'(out_pc),    sz > 0 ? 64'(q[0].pc)   : 64'd0);
    check("m_out_npc",   64'(out_npc),   sz > 0 ? 64'(q[0].npc)  : 64'd0);
    check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
  end

  // Drive one cycle of inputs, return at the following falling edge.
  task automatic cyc(bit v, logic [31:0] pc, bit rdy, bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_npc    = pc + 32'd4;
    in_inst   = 32'hA000_0000 | pc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_occ",   64'(occupancy), 64'd0);
    check("rst_inst",  64'(out_inst),  64'(NOP));
    check("rst_ready", 64'(in_ready),  64'd1);
    rst_n = 1'b1;

    // streaming
    cyc(1, 32'h0, 1, 0);  check("st_pc0", 64'(out_pc), 64'h0);
    check("st_npc0", 64'(out_npc), 64'h4);
    cyc(1, 32'h4, 1, 0);  check("st_pc4", 64'(out_pc), 64'h4);
    cyc(1, 32'h8, 1, 0);  check("st_pc8", 64'(out_pc), 64'h8);
    check("st_inst8", 64'(out_inst), 64'hA000_0008);
    check("st_occ", 64'(occupancy), 64'd1);
    check("st_stall", 64'(stall_cnt), 64'd0);
    cyc(0, 32'h0, 1, 0);  check("st_drain", 64'(out_valid), 64'd0);

    // back-pressure
    cyc(1, 32'h100, 0, 0); check("bp_occ1", 64'(occupancy), 64'd1);
    cyc(1, 32'h104, 0, 0); check("bp_occ2", 64'(occupancy), 64'd2);
    check("bp_rdy0", 64'(in_ready), 64'd0);
    check("bp_headA", 64'(out_pc), 64'h100);
    cyc(0, 32'h0, 0, 0);   check("bp_stall", 64'(stall_cnt), 64'd2);
    cyc(0, 32'h0, 1, 0);   check("bp_B", 64'(out_pc), 64'h104);
    check("bp_occ_after", 64'(occupancy), 64'd1);
    cyc(0, 32'h0, 1, 0);   check("bp_empty", 64'(occupancy), 64'd0);

    // flush while FULL with C offered
    cyc(1, 32'h200, 0, 0);
    cyc(1, 32'h204, 0, 0); check("fl_full", 64'(occupancy), 64'd2);
    cyc(1, 32'h208, 0, 1); check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_vld", 64'(out_valid), 64'd0);
    check("fl_nop", 64'(out_inst), 64'(NOP));
    check("fl_stall", 64'(stall_cnt), 64'd3);
    cyc(0, 32'h0, 1, 0);   check("fl_noC", 64'(out_valid), 64'd0);
    // flush while ONE with an accepted offer: both discarded
    cyc(1, 32'h300, 0, 0);
    cyc(1, 32'h304, 1, 1); check("fl1_occ", 64'(occupancy), 64'd0);
    cyc(0, 32'h0, 1, 0);   check("fl1_empty", 64'(out_valid), 64'd0);

    // saturation
    cyc(1, 32'h400, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 32'h0, 0, 0);
    check("sat15", 64'(stall_cnt), 64'd15);
    cyc(1, 32'h404, 0, 0); check("sat_hold", 64'(stall_cnt), 64'd15);
    check("sat_full", 64'(occupancy), 64'd2);

    // async reset mid-cycle while FULL
    #2 rst_n = 1'b0;
    #1;
    check("ar_occ",   64'(occupancy), 64'd0);
    check("ar_vld",   64'(out_valid), 64'd0);
    check("ar_rdy",   64'(in_ready),  64'd1);
    check("ar_inst",  64'(out_inst),  64'(NOP));
    check("ar_pc",    64'(out_pc),    64'd0);
    check("ar_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    cyc(0, 32'h0, 1, 0);
    rst_n = 1'b1;
    cyc(1, 32'h500, 1, 0); check("ar_D", 64'(out_pc), 64'h500);
    check("ar_Dnpc", 64'(out_npc), 64'h504);
    cyc(0, 32'h0, 1, 0);   check("ar_end", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
